// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, memOffset encodings, FSM state type and request decode helpers
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] OFF_BYTE = 3'b001;
    localparam logic [2:0] OFF_HALF = 3'b010;
    localparam logic [2:0] OFF_WORD = 3'b100;
    typedef enum logic [1:0] {IDLE, ACCESS, BYTE, RESP} state_t;
    // Loads accept B/H/W/BU/HU, stores only B/H/W.
    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        return we ? (f3 >= 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == F3_H[1:0] && a[0]) || (f3[1:0] == F3_W[1:0] && a != 2'b00);
    endfunction
    function automatic logic [2:0] size_off(input logic [2:0] f3);
        return f3[1] ? OFF_WORD : (f3[0] ? OFF_HALF : OFF_BYTE);
    endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake between the pipeline (master) and the load/store unit (slave)
//   req_valid/req_ready handshake, req_we/req_funct3/req_addr/req_wdata request fields,
//   resp_valid one-cycle strobe with resp_rdata and resp_err.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_extend.sv
// lsu_extend: combinational sign/zero extension of load data selected by funct3
//   funct3 in: load type; din in: raw assembled data; dout out: extended data (0 for unknown codes)
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    always_comb begin
        dout = funct3 == F3_B  ? {{24{din[7]}}, din[7:0]} :
               funct3 == F3_BU ? {24'b0, din[7:0]} :
               funct3 == F3_H  ? {{16{din[15]}}, din[15:0]} :
               funct3 == F3_HU ? {16'b0, din[15:0]} :
               funct3 == F3_W  ? din : 32'b0;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of the data memory
//   clk, rst (async, active-low); bus: lsu_if slave (request/response handshake);
//   MemRead/MemWrite/memOffset/unsignedFlag/addr/data_in drive the memory, mem_rdata is its read data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    lsu_if.slave        bus,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  memOffset,
    output logic        unsignedFlag,
    output logic [31:0] addr,
    output logic [31:0] data_in,
    input  logic [31:0] mem_rdata
);
    state_t      state, state_nx;
    logic        we_q, err_q, rdy_en;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, asm_q, ext;
    logic [1:0]  idx;
    logic        go, bad, mis, rej, last;

    assign go   = bus.req_valid & bus.req_ready;
    assign bad  = illegal_f3(bus.req_we, bus.req_funct3);
    assign mis  = misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign rej  = bad || (mis && !ALLOW_MISALIGNED);
    assign last = idx == (f3_q[1] ? 2'd3 : 2'd1);

    always_comb begin
        state_nx = state == IDLE   ? (go ? (rej ? RESP : (mis ? BYTE : ACCESS)) : IDLE) :
                   state == ACCESS ? RESP :
                   state == BYTE   ? (last ? RESP : BYTE) : IDLE;
    end

    always_comb begin
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        memOffset    = 3'b000;
        unsignedFlag = 1'b0;
        addr         = 32'b0;
        data_in      = 32'b0;
        if (state == ACCESS) begin
            MemRead      = !we_q;
            MemWrite     = we_q;
            memOffset    = size_off(f3_q);
            unsignedFlag = !we_q && f3_q[2];
            addr         = addr_q;
            data_in      = wdata_q;
        end else if (state == BYTE) begin
            MemRead      = !we_q;
            MemWrite     = we_q;
            memOffset    = OFF_BYTE;
            unsignedFlag = 1'b1;
            addr         = addr_q + {30'b0, idx};
            data_in      = {24'b0, wdata_q[{idx, 3'b000} +: 8]};
        end
    end

    // rdy_en keeps req_ready low while reset is held and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            rdy_en  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            asm_q   <= 32'b0;
        end else begin
            state  <= state_nx;
            rdy_en <= 1'b1;
            if (go) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= rej;
                asm_q   <= 32'b0;
                idx     <= 2'd0;
            end
            if (state == ACCESS) asm_q <= mem_rdata;
            if (state == BYTE) begin
                asm_q[{idx, 3'b000} +: 8] <= mem_rdata[7:0];
                idx <= idx + 2'd1;
            end
        end
    end

    lsu_extend u_ext (.funct3(f3_q), .din(asm_q), .dout(ext));

    assign bus.req_ready  = state == IDLE && rdy_en;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_err   = state == RESP && err_q;
    assign bus.resp_rdata = (state == RESP && !we_q && !err_q) ? ext : 32'b0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-array reference model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if b1();
    lsu_if b0();
    logic        rd1, wr1, uf1, rd0, wr0, uf0;
    logic [2:0]  off1, off0;
    logic [31:0] a1, d1, m1, a0, d0, raw1;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .MemRead(rd1), .MemWrite(wr1), .memOffset(off1),
        .unsignedFlag(uf1), .addr(a1), .data_in(d1), .mem_rdata(m1));
    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0), .MemRead(rd0), .MemWrite(wr0), .memOffset(off0),
        .unsignedFlag(uf0), .addr(a0), .data_in(d0), .mem_rdata(32'h89ABCDEF));

    int errors = 0, checks = 0, viol = 0, resp_seen1 = 0, n_acc0 = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_a, poke_d;

    typedef struct packed {logic we; logic [2:0] off; logic uf; logic [31:0] a; logic [31:0] d;} acc_t;
    acc_t log1 [$];

    // Data memory behind dut1: combinational read with its own extension, byte-lane writes at the edge.
    assign raw1 = {mem[8'(a1 + 32'd3)], mem[8'(a1 + 32'd2)], mem[8'(a1 + 32'd1)], mem[a1[7:0]]};
    assign m1 = !rd1 ? 32'h0 :
                off1 == 3'b100 ? raw1 :
                off1 == 3'b010 ? {{16{!uf1 & raw1[15]}}, raw1[15:0]} :
                {{24{!uf1 & raw1[7]}}, raw1[7:0]};

    always @(posedge clk) begin
        if (poke_en) mem[poke_a] = poke_d;
        else if (wr1) begin
            mem[a1[7:0]] = d1[7:0];
            if (off1 != 3'b001) mem[8'(a1 + 32'd1)] = d1[15:8];
            if (off1 == 3'b100) begin
                mem[8'(a1 + 32'd2)] = d1[23:16];
                mem[8'(a1 + 32'd3)] = d1[31:24];
            end
        end
        if (rd1 || wr1) log1.push_back({wr1, off1, uf1, a1, d1});
        if (rd0 || wr0) n_acc0++;
    end

    always @(negedge clk) begin
        if (!rd1 && !wr1 && (a1 != 32'h0 || d1 != 32'h0)) viol++;
        if (rd1 && wr1) viol++;
        if (b1.resp_valid) resp_seen1++;
    end

    task automatic poke(input logic [7:0] pa, input logic [7:0] pd);
        poke_en = 1'b1; poke_a = pa; poke_d = pd; ref_mem[pa] = pd;
        @(posedge clk); @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Reference: access size from funct3, alignment by address modulo size, bytes little-endian.
    task automatic model(input logic allow, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
        int n;
        logic ill, mis;
        n = f3[1:0] == 2'd0 ? 1 : (f3[1:0] == 2'd1 ? 2 : 4);
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
        mis = (a % 32'(n)) != 0;
        rd = 32'h0;
        er = ill || (mis && !allow);
        lat = er ? 1 : (mis ? 1 + n : 2);
        if (!er)
            for (int i = 0; i < n; i++)
                if (we) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
                else rd[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        if (!er && !we && !f3[2] && n < 4) rd = n == 1 ? {{24{rd[7]}}, rd[7:0]} : {{16{rd[15]}}, rd[15:0]};
    endtask

    task automatic do_req(input logic sel, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
        int w;
        w = 0;
        while (!(sel ? b1.req_ready : b0.req_ready) && w < 20) begin @(negedge clk); w++; end
        checks++;
        if ((sel ? b1.req_ready : b0.req_ready) !== 1'b1) begin
            errors++; $display("FAIL ready_before_req: req_ready=%b required 1", sel ? b1.req_ready : b0.req_ready);
        end
        if (sel) begin b1.req_valid = 1'b1; b1.req_we = we; b1.req_funct3 = f3; b1.req_addr = a; b1.req_wdata = wd; end
        else begin b0.req_valid = 1'b1; b0.req_we = we; b0.req_funct3 = f3; b0.req_addr = a; b0.req_wdata = wd; end
        @(posedge clk); @(negedge clk);
        b1.req_valid = 1'b0; b0.req_valid = 1'b0;
        lat = 1;
        while (!(sel ? b1.resp_valid : b0.resp_valid) && lat < 20) begin @(negedge clk); lat++; end
        rd = sel ? b1.resp_rdata : b0.resp_rdata;
        er = sel ? b1.resp_err : b0.resp_err;
        @(negedge clk);
        checks++;
        if ((sel ? b1.req_ready : b0.req_ready) !== 1'b1) begin
            errors++; $display("FAIL ready_after_resp: req_ready=%b required 1", sel ? b1.req_ready : b0.req_ready);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({b1.req_ready, b1.resp_valid, b1.resp_err, b1.resp_rdata, rd1, wr1, off1, uf1, a1, d1, b0.req_ready} !== '0) begin
            errors++; $display("FAIL reset_outputs: ready=%b rv=%b rd=%b wr=%b addr=%h required all 0", b1.req_ready, b1.resp_valid, rd1, wr1, a1);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if ({b1.req_ready, b0.req_ready, b1.resp_valid, rd1, wr1} !== 5'b0) begin
            errors++; $display("FAIL reset_held: ready1=%b ready0=%b rv=%b required 0", b1.req_ready, b0.req_ready, b1.resp_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({b1.req_ready, b0.req_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_release_ready: ready1=%b ready0=%b required 1", b1.req_ready, b0.req_ready);
        end
    endtask

    task automatic test_sw_aligned();
        int base, lat, el; logic [31:0] rd, erd; logic er, ee;
        base = log1.size();
        model(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, el, erd, ee);
        do_req(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d required 2", lat); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL sw_resp: err=%b rdata=%h required 0/0", er, rd); end
        checks++;
        if (log1.size() - base !== 1) begin errors++; $display("FAIL sw_cycles: got %0d required 1", log1.size() - base); end
        else if (log1[base] !== {1'b1, 3'b100, 1'b0, 32'h10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL sw_access: got %h required write word 0x10 DEADBEEF", log1[base]);
        end
    endtask

    task automatic test_loads();
        logic [31:0] rd, erd; logic er, ee; int lat, el;
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] as  [3] = '{32'h10, 32'h10, 32'h12};
        logic [31:0] exs [3] = '{32'hFFFFFFEF, 32'h000000EF, 32'hFFFFDEAD};
        for (int i = 0; i < 3; i++) begin
            model(1'b1, 1'b0, f3s[i], as[i], 32'h0, el, erd, ee);
            do_req(1'b1, 1'b0, f3s[i], as[i], 32'h0, lat, rd, er);
            checks++;
            if (rd !== exs[i] || er !== 1'b0 || lat !== 2) begin
                errors++; $display("FAIL load_%0d: rdata=%h err=%b lat=%0d required %h/0/2", i, rd, er, lat, exs[i]);
            end
        end
    endtask

    task automatic test_misaligned_lw();
        int base, lat, el; logic [31:0] rd, erd; logic er, ee;
        poke(8'h11, 8'hBE); poke(8'h12, 8'hAD); poke(8'h13, 8'hDE); poke(8'h14, 8'h00);
        base = log1.size();
        model(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, el, erd, ee);
        do_req(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h00DEADBE || erd !== 32'h00DEADBE) begin errors++; $display("FAIL lw_mis_data: got %h required 00DEADBE", rd); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL lw_mis_latency: resp at %0d required 5 (ready at 6)", lat); end
        checks++;
        if (log1.size() - base !== 4) begin errors++; $display("FAIL lw_mis_cycles: got %0d required 4", log1.size() - base); end
        else for (int i = 0; i < 4; i++)
            if (log1[base + i] !== {1'b0, 3'b001, 1'b1, 32'h11 + 32'(i), 32'h0}) begin
                errors++; $display("FAIL lw_mis_byte%0d: got %h required byte read at %h", i, log1[base + i], 32'h11 + 32'(i));
            end
        base = log1.size();
        model(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, el, erd, ee);
        do_req(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat, rd, er);
        checks++; if (rd !== erd) begin errors++; $display("FAIL lw_wrap_data: got %h required %h", rd, erd); end
        checks++;
        if (log1.size() - base !== 4) begin errors++; $display("FAIL lw_wrap_cycles: got %0d required 4", log1.size() - base); end
        else if (log1[base + 2].a !== 32'h0) begin errors++; $display("FAIL lw_wrap_addr: got %h required 0", log1[base + 2].a); end
    endtask

    task automatic test_misaligned_sh();
        int base, lat, el, n0; logic [31:0] rd, erd; logic er, ee;
        base = log1.size();
        model(1'b1, 1'b1, 3'b001, 32'h13, 32'h1234, el, erd, ee);
        do_req(1'b1, 1'b1, 3'b001, 32'h13, 32'h1234, lat, rd, er);
        checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL sh_mis_resp: lat=%0d err=%b required 3/0", lat, er); end
        checks++;
        if (log1.size() - base !== 2) begin errors++; $display("FAIL sh_mis_cycles: got %0d required 2", log1.size() - base); end
        else if (log1[base] !== {1'b1, 3'b001, 1'b1, 32'h13, 32'h34} || log1[base + 1] !== {1'b1, 3'b001, 1'b1, 32'h14, 32'h12}) begin
            errors++; $display("FAIL sh_mis_access: got %h %h required 34@13 then 12@14", log1[base], log1[base + 1]);
        end
        checks++; if ({mem[8'h13], mem[8'h14]} !== 16'h3412) begin errors++; $display("FAIL sh_mis_mem: got %h%h required 3412", mem[8'h13], mem[8'h14]); end
        n0 = n_acc0;
        do_req(1'b0, 1'b1, 3'b001, 32'h13, 32'h1234, lat, rd, er);
        checks++;
        if (er !== 1'b1 || lat !== 1 || rd !== 32'h0 || n_acc0 !== n0) begin
            errors++; $display("FAIL sh_reject: err=%b lat=%0d rdata=%h strobes=%0d required 1/1/0/0", er, lat, rd, n_acc0 - n0);
        end
        do_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || lat !== 2 || rd !== 32'h89ABCDEF || n_acc0 !== n0 + 1) begin
            errors++; $display("FAIL lw_aligned_strict: err=%b lat=%0d rdata=%h strobes=%0d required 0/2/89ABCDEF/1", er, lat, rd, n_acc0 - n0);
        end
    endtask

    task automatic test_illegal();
        int base, lat; logic [31:0] rd; logic er;
        logic       wes [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0] f3s [3] = '{3'b011, 3'b111, 3'b011};
        for (int i = 0; i < 3; i++) begin
            base = log1.size();
            do_req(1'b1, wes[i], f3s[i], 32'h40, 32'hFFFFFFFF, lat, rd, er);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || log1.size() !== base) begin
                errors++; $display("FAIL illegal_%0d: err=%b rdata=%h lat=%0d strobes=%0d required 1/0/1/0", i, er, rd, lat, log1.size() - base);
            end
        end
    endtask

    task automatic test_back_to_back();
        int el; logic [31:0] ea, eb; logic ee;
        model(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, el, ea, ee);
        model(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, el, eb, ee);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_funct3 = 3'b010; b1.req_addr = 32'h10;
        @(posedge clk); @(negedge clk);
        checks++; if (b1.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready: got %b required 0", b1.req_ready); end
        b1.req_funct3 = 3'b100; b1.req_addr = 32'h11;
        @(negedge clk);
        checks++; if (b1.resp_valid !== 1'b1 || b1.resp_rdata !== ea) begin errors++; $display("FAIL b2b_first: rv=%b rdata=%h required 1/%h", b1.resp_valid, b1.resp_rdata, ea); end
        @(negedge clk);
        @(negedge clk);
        b1.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (b1.resp_valid !== 1'b1 || b1.resp_rdata !== eb) begin errors++; $display("FAIL b2b_second: rv=%b rdata=%h required 1/%h", b1.resp_valid, b1.resp_rdata, eb); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, el, r, diffs; logic [31:0] a, wd, rd, erd; logic [2:0] f3; logic we, er, ee;
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 4);
            f3 = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) : (we ? 3'(r % 3) : (r < 3 ? 3'(r) : 3'(r + 1)));
            a = $urandom_range(0, 4) == 0 ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 255));
            wd = $urandom;
            model(1'b1, we, f3, a, wd, el, erd, ee);
            do_req(1'b1, we, f3, a, wd, lat, rd, er);
            checks++;
            if (rd !== erd || er !== ee || lat !== el) begin
                errors++; $display("FAIL rand_%0d we=%b f3=%b a=%h: rdata=%h err=%b lat=%0d required %h/%b/%0d", k, we, f3, a, rd, er, lat, erd, ee, el);
            end
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        checks++; if (diffs !== 0) begin errors++; $display("FAIL rand_memory: %0d bytes differ, required 0", diffs); end
    endtask

    task automatic test_reset_mid_split();
        int rc;
        for (int i = 0; i < 4; i++) poke(8'h21 + 8'(i), 8'h55);
        rc = resp_seen1;
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_funct3 = 3'b010; b1.req_addr = 32'h21; b1.req_wdata = 32'hA1B2C3D4;
        @(posedge clk); @(negedge clk);
        b1.req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (!(wr1 === 1'b1 && a1 === 32'h23)) begin errors++; $display("FAIL split_idx2: wr=%b addr=%h required 1/23", wr1, a1); end
        rst = 1'b0;
        #1;
        checks++;
        if ({b1.req_ready, b1.resp_valid, b1.resp_err, b1.resp_rdata, rd1, wr1, off1, uf1, a1, d1} !== '0) begin
            errors++; $display("FAIL split_reset_outputs: wr=%b addr=%h data=%h off=%b required all 0", wr1, a1, d1, off1);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL split_ready_release: got %b required 1", b1.req_ready); end
        @(negedge clk); @(negedge clk);
        checks++; if (resp_seen1 !== rc) begin errors++; $display("FAIL split_no_resp: %0d responses required 0", resp_seen1 - rc); end
        checks++;
        if ({mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]} !== 32'hD4C35555) begin
            errors++; $display("FAIL split_mem: got %h%h%h%h required D4C35555", mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]);
        end
    endtask

    initial begin
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_funct3 = 3'b0; b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_funct3 = 3'b0; b0.req_addr = 32'h0; b0.req_wdata = 32'h0;
        test_reset();
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        test_sw_aligned();
        test_loads();
        test_misaligned_lw();
        test_misaligned_sh();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_split();
        checks++; if (viol !== 0) begin errors++; $display("FAIL idle_bus_zero: %0d cycles with addr/data_in nonzero or both strobes, required 0", viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
